// File: rtl/jtag_axi_pkg.sv
// -----------------------------------------------------------------------------
// jtag_axi_pkg
// Shared types and constants for the JTAG-to-AXI4 bridge.
//   state_t         : bridge FSM state encoding
//   AXI_BURST_INCR  : AXI incrementing burst type
//   RESP_*          : AXI response codes
// -----------------------------------------------------------------------------
package jtag_axi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RADDR = 3'd4,
        RDATA = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/jtag_axi_beat_buf.sv
// -----------------------------------------------------------------------------
// jtag_axi_beat_buf
// Read buffer for the bridge: MAX_BEATS registers of DATA_W bits each. One
// beat is written per cycle, selected by idx; unwritten beats keep their value.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears all beats)
//   we, idx  : write enable and beat index
//   wdata    : beat data to store
//   rdata    : all beats, beat k in slice k
// -----------------------------------------------------------------------------
module jtag_axi_beat_buf #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [IDX_W-1:0]              idx,
    input  logic [DATA_W-1:0]             wdata,
    output logic [MAX_BEATS*DATA_W-1:0]   rdata
);

    logic [MAX_BEATS*DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            for (int i = 0; i < MAX_BEATS; i++) begin
                if (idx == IDX_W'(i)) begin
                    mem[i*DATA_W +: DATA_W] <= wdata;
                end
            end
        end
    end

    assign rdata = mem;

endmodule

// File: rtl/jtag_axi_bridge.sv
// -----------------------------------------------------------------------------
// jtag_axi_bridge
// Turns a captured JTAG request (launched by a one-cycle update pulse) into a
// single AXI4 INCR burst, either a store (AW/W/B) or a load (AR/R).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   update_i, req_*     : request launch pulse and request fields
//   rdata_o             : read buffer, beat k in slice k
//   busy_o, done_o      : request in flight, one-cycle completion pulse
//   resp_o              : collected AXI response
//   len_err_o           : r_last arrived on the wrong beat
//   overrun_o           : update_i seen while busy (sticky)
//   aw_*, w_*, b_*,
//   ar_*, r_*           : AXI4 master channels (IDs implicitly 0)
// Build option:
//   JTAG_AXI_WSTRB_EN   : when defined, w_strb comes from req_wstrb_i;
//                         otherwise all byte lanes are written.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for update_i
// WADDR | aw_valid asserted, waiting for aw_ready
// WDATA | streaming write beats, w_last on the final one
// WRESP | b_ready asserted, waiting for the write response
// RADDR | ar_valid asserted, waiting for ar_ready
// RDATA | r_ready asserted, collecting beats until r_last
// -----------------------------------------------------------------------------
module jtag_axi_bridge
    import jtag_axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 4,
    localparam int LEN_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          update_i,
    input  logic                          req_we_i,
    input  logic [ADDR_W-1:0]             req_addr_i,
    input  logic [LEN_W-1:0]              req_len_i,
    input  logic [MAX_BEATS*DATA_W-1:0]   req_wdata_i,
    input  logic [MAX_BEATS*STRB_W-1:0]   req_wstrb_i,

    output logic [MAX_BEATS*DATA_W-1:0]   rdata_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [1:0]                    resp_o,
    output logic                          len_err_o,
    output logic                          overrun_o,

    output logic [ADDR_W-1:0]             aw_addr,
    output logic [7:0]                    aw_len,
    output logic [2:0]                    aw_size,
    output logic [1:0]                    aw_burst,
    output logic                          aw_valid,
    input  logic                          aw_ready,

    output logic [DATA_W-1:0]             w_data,
    output logic [STRB_W-1:0]             w_strb,
    output logic                          w_last,
    output logic                          w_valid,
    input  logic                          w_ready,

    input  logic [1:0]                    b_resp,
    input  logic                          b_valid,
    output logic                          b_ready,

    output logic [ADDR_W-1:0]             ar_addr,
    output logic [7:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    output logic                          ar_valid,
    input  logic                          ar_ready,

    input  logic [DATA_W-1:0]             r_data,
    input  logic [1:0]                    r_resp,
    input  logic                          r_last,
    input  logic                          r_valid,
    output logic                          r_ready
);

    localparam int OFF_W = $clog2(STRB_W);
    // One extra bit so beats past the captured length stay distinguishable.
    localparam int K_W   = LEN_W + 1;

    state_t                      state, state_nxt;
    logic [ADDR_W-1:OFF_W]       addr_q;
    logic [LEN_W-1:0]            len_q;
    logic [MAX_BEATS*DATA_W-1:0] wdata_q;
    logic [K_W-1:0]              k_q;
    logic [1:0]                  resp_q;
    logic                        len_err_q;
    logic                        overrun_q;
    logic                        done_q;

    logic                        accept;
    logic                        w_hs, b_hs, r_hs;
    logic                        k_at_len;
    logic                        k_in_range;
    logic [LEN_W-1:0]            k_idx;
    logic [ADDR_W-1:0]           axi_addr;

    assign accept     = (state == IDLE) && update_i;
    assign w_hs       = (state == WDATA) && w_ready;
    assign b_hs       = (state == WRESP) && b_valid;
    assign r_hs       = (state == RDATA) && r_valid;
    assign k_at_len   = (k_q == {1'b0, len_q});
    assign k_in_range = (k_q <= {1'b0, len_q});
    assign k_idx      = k_q[LEN_W-1:0];
    assign axi_addr   = {addr_q, {OFF_W{1'b0}}};

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (update_i)             state_nxt = req_we_i ? WADDR : RADDR;
            WADDR: if (aw_ready)             state_nxt = WDATA;
            WDATA: if (w_ready && k_at_len)  state_nxt = WRESP;
            WRESP: if (b_valid)              state_nxt = IDLE;
            RADDR: if (ar_ready)             state_nxt = RDATA;
            RDATA: if (r_valid && r_last)    state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy_o   = (state != IDLE);
        aw_valid = (state == WADDR);
        w_valid  = (state == WDATA);
        b_ready  = (state == WRESP);
        ar_valid = (state == RADDR);
        r_ready  = (state == RDATA);
        w_last   = (state == WDATA) && k_at_len;

        aw_addr  = axi_addr;
        aw_len   = 8'(len_q);
        aw_size  = 3'(OFF_W);
        aw_burst = AXI_BURST_INCR;
        ar_addr  = axi_addr;
        ar_len   = 8'(len_q);
        ar_size  = 3'(OFF_W);
        ar_burst = AXI_BURST_INCR;

        w_data = '0;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (k_idx == LEN_W'(i)) begin
                w_data = wdata_q[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef JTAG_AXI_WSTRB_EN
    logic [MAX_BEATS*STRB_W-1:0] wstrb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wstrb_q <= '0;
        end else if (accept) begin
            wstrb_q <= req_wstrb_i;
        end
    end

    always_comb begin
        w_strb = '0;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (k_idx == LEN_W'(i)) begin
                w_strb = wstrb_q[i*STRB_W +: STRB_W];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^req_addr_i[OFF_W-1:0];
`else
    assign w_strb = '1;

    logic unused_ok;
    assign unused_ok = ^{req_addr_i[OFF_W-1:0], req_wstrb_i};
`endif

    // ---------------- request capture and status ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            k_q       <= '0;
            resp_q    <= RESP_OKAY;
            len_err_q <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= b_hs || (r_hs && r_last);

            if (accept) begin
                addr_q    <= req_addr_i[ADDR_W-1:OFF_W];
                len_q     <= req_len_i;
                wdata_q   <= req_wdata_i;
                k_q       <= '0;
                resp_q    <= RESP_OKAY;
                len_err_q <= 1'b0;
                overrun_q <= 1'b0;
            end else if (update_i) begin
                overrun_q <= 1'b1;
            end

            if (w_hs) begin
                k_q <= k_q + 1'b1;
            end

            if (b_hs) begin
                resp_q <= b_resp;
            end

            if (r_hs) begin
                // Saturate so a runaway burst can never alias back into range.
                if (k_q != '1) begin
                    k_q <= k_q + 1'b1;
                end
                if (resp_q == RESP_OKAY && r_resp != RESP_OKAY) begin
                    resp_q <= r_resp;
                end
                if (r_last) begin
                    len_err_q <= !k_at_len;
                end
            end
        end
    end

    jtag_axi_beat_buf #(
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .IDX_W     (LEN_W)
    ) u_beat_buf (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (r_hs && k_in_range),
        .idx   (k_idx),
        .wdata (r_data),
        .rdata (rdata_o)
    );

    assign resp_o    = resp_q;
    assign len_err_o = len_err_q;
    assign overrun_o = overrun_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_jtag_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_jtag_axi_bridge
// Directed bench for jtag_axi_bridge (default parameters). The bench plays the
// AXI slave itself, cycle by cycle, and compares the bridge against expected
// write beats and read-buffer contents kept in queues.
// -----------------------------------------------------------------------------
module tb_jtag_axi_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MB     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              update = 1'b0;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [1:0]        req_len = '0;
    logic [255:0]      req_wdata = '0;
    logic [31:0]       req_wstrb = '0;
    logic [255:0]      rdata;
    logic              busy, done, len_err, overrun;
    logic [1:0]        resp;
    logic [31:0]       aw_addr, ar_addr;
    logic [7:0]        aw_len, ar_len;
    logic [2:0]        aw_size, ar_size;
    logic [1:0]        aw_burst, ar_burst;
    logic              aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
    logic              aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
    logic [63:0]       w_data;
    logic [7:0]        w_strb;
    logic [1:0]        b_resp = '0;
    logic              b_valid = 1'b0;
    logic [63:0]       r_data = '0;
    logic [1:0]        r_resp = '0;
    logic              r_last = 1'b0, r_valid = 1'b0;

    always #5 clk = ~clk;

    jtag_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MB)) dut (
        .clk_i(clk), .rst_i(rst),
        .update_i(update), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_len_i(req_len), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rdata_o(rdata), .busy_o(busy), .done_o(done), .resp_o(resp),
        .len_err_o(len_err), .overrun_o(overrun),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid),
        .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
        .r_ready(r_ready)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } wexp_t;

    wexp_t       wq[$];
    logic [63:0] rq[$];
    logic [63:0] exp_rd[MB];
    int          errors = 0;
    int          checks = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input int len, input logic [255:0] wd,
                            input logic [31:0] ws, input logic [1:0] bresp);
        wexp_t e;
        req_we = 1'b1; req_addr = addr; req_len = 2'(len);
        req_wdata = wd; req_wstrb = ws; update = 1'b1;
        for (int i = 0; i <= len; i++) begin
            e.data = wd[i*64 +: 64];
`ifdef JTAG_AXI_WSTRB_EN
            e.strb = ws[i*8 +: 8];
`else
            e.strb = 8'hFF;
`endif
            e.last = (i == len);
            wq.push_back(e);
        end
        step();
        update = 1'b0;
        chk("aw_valid", aw_valid, 1);
        chk("aw_addr", aw_addr, {addr[31:3], 3'b000});
        chk("aw_len", aw_len, len);
        chk("aw_size", aw_size, 3);
        chk("aw_burst", aw_burst, 2'b01);
        chk("busy_store", busy, 1);
        aw_ready = 1'b1;
        step();
        aw_ready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            chk("w_valid", w_valid, 1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("w_data", w_data, e.data);
                chk("w_strb", w_strb, e.strb);
                chk("w_last", w_last, e.last);
            end
            w_ready = 1'b1;
            step();
            w_ready = 1'b0;
        end
        chk("b_ready", b_ready, 1);
        b_valid = 1'b1; b_resp = bresp;
        step();
        b_valid = 1'b0;
        chk("store_done", done, 1);
        chk("store_idle", busy, 0);
        chk("store_resp", resp, bresp);
        chk("store_overrun", overrun, 0);
        step();
        chk("store_done_clr", done, 0);
    endtask

    task automatic do_load(input logic [31:0] addr, input int len, input int nbeats,
                           input int last_at, input int gap, input logic [7:0] resps,
                           input int upd_at, input logic [31:0] seed);
        logic [1:0]  er;
        logic [63:0] d;
        logic [63:0] got;
        er = 2'b00;
        req_we = 1'b0; req_addr = addr; req_len = 2'(len); update = 1'b1;
        step();
        update = 1'b0;
        chk("ar_valid", ar_valid, 1);
        chk("ar_addr", ar_addr, {addr[31:3], 3'b000});
        chk("ar_len", ar_len, len);
        chk("ar_size", ar_size, 3);
        chk("ar_burst", ar_burst, 2'b01);
        ar_ready = 1'b1;
        step();
        ar_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            r_valid = 1'b0;
            repeat (gap) begin
                step();
                chk("done_early", done, 0);
            end
            d = {seed, 32'(i)};
            r_data = d; r_resp = resps[2*i +: 2]; r_last = (i == last_at); r_valid = 1'b1;
            if (i <= len) exp_rd[i] = d;
            if (er == 2'b00) er = resps[2*i +: 2];
            if (i == upd_at) begin
                update = 1'b1; req_we = 1'b1; req_addr = 32'h0000_BAD0;
            end
            chk("r_ready", r_ready, 1);
            step();
            update = 1'b0;
            if (i == last_at) break;
        end
        r_valid = 1'b0; r_last = 1'b0;
        for (int j = 0; j < MB; j++) rq.push_back(exp_rd[j]);
        chk("load_done", done, 1);
        chk("load_idle", busy, 0);
        chk("load_len_err", len_err, (last_at != len));
        chk("load_resp", resp, er);
        chk("load_overrun", overrun, (upd_at >= 0));
        for (int j = 0; j < MB; j++) begin
            if (rq.size() > 0) begin
                got = rdata[j*64 +: 64];
                chk("rdata_beat", got, rq.pop_front());
            end
        end
        step();
        chk("load_done_clr", done, 0);
        chk("load_stay_idle", busy, 0);
        chk("load_no_aw", aw_valid, 0);
    endtask

    initial begin
        for (int j = 0; j < MB; j++) exp_rd[j] = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aw_valid", aw_valid, 0);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", resp, 0);
        step();

        // single-beat store, unaligned address
        do_store(32'h1000_0007, 0, {192'h0, 64'hDEAD_BEEF_0123_4567}, 32'hFFFF_FFFF, 2'b00);
        // 4-beat load, 3 idle cycles before each beat
        do_load(32'h2000_0010, 3, 4, 3, 3, 8'h00, -1, 32'hA5A5_0001);
        // SLVERR on beat 0 must survive an OKAY on beat 1
        do_load(32'h2000_0020, 1, 2, 1, 0, 8'b0000_0010, -1, 32'hA5A5_0002);
        // early r_last
        do_load(32'h2000_0030, 3, 2, 1, 0, 8'h00, -1, 32'hA5A5_0003);
        // extra beat beyond length is discarded
        do_load(32'h2000_0040, 0, 2, 1, 1, 8'b0000_1100, -1, 32'hA5A5_0004);
        // update during RDATA, then on the final handshake
        do_load(32'h2000_0050, 3, 4, 3, 0, 8'h00, 1, 32'hA5A5_0005);
        do_load(32'h2000_0060, 1, 2, 1, 1, 8'h00, 1, 32'hA5A5_0006);
        // multi-beat store with partial strobe on beat 0; overrun clears on accept
        do_store(32'h3000_0000, 3,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                 32'hF0_3C_FF_0F, 2'b10);

        // reset while in WDATA
        req_we = 1'b1; req_addr = 32'h4000_0000; req_len = 2'd3;
        req_wdata = {4{64'hCAFE_F00D_0000_0000}}; update = 1'b1;
        step();
        update = 1'b0;
        aw_ready = 1'b1;
        step();
        aw_ready = 1'b0;
        chk("pre_rst_w_valid", w_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("wrst_aw_valid", aw_valid, 0);
        chk("wrst_w_valid", w_valid, 0);
        chk("wrst_ar_valid", ar_valid, 0);
        chk("wrst_b_ready", b_ready, 0);
        chk("wrst_r_ready", r_ready, 0);
        chk("wrst_busy", busy, 0);
        chk("wrst_rdata", rdata, 0);
        chk("wrst_resp", resp, 0);
        for (int j = 0; j < MB; j++) exp_rd[j] = '0;
        step();

        do_store(32'h5000_0008, 1, {128'h0, 64'h0BAD_CAFE_0000_0002, 64'h0BAD_CAFE_0000_0001},
                 32'h0000_00FF, 2'b00);
        do_load(32'h6000_0000, 1, 2, 1, 0, 8'b0000_1100, -1, 32'hA5A5_0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
